mem_access_stage: RTL and testbench

- MEM stage of the 5-stage RV32I pipeline. Consumes the EX/MEM register outputs (ALU result, store data, memory control) and performs the data-memory access over a req/gnt/rvalid bus.
- Stalls the pipeline until the access completes.
- Produces the write-back value for the MEM/WB register: the formatted load data or the pass-through ALU result.

---
 rtl/rv_pkg.sv | 45 ++++
 rtl/load_formatter.sv | 33 +++
 rtl/mem_access_stage.sv | 136 +++++++++++++
 tb/tb_mem_access_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I load/store encodings, MEM-stage FSM states and lane helpers.
// Imported by the MEM stage and the load formatter.
package rv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;

  // Unknown funct3 encodings are reported as misaligned so they raise a fault.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return off[0];
      F3_W:        return (off != 2'b00);
      default:     return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return BE_BYTE << off;
      F3_H, F3_HU: return BE_HALF << off;
      F3_W:        return BE_WORD;
      default:     return BE_NONE;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3)
      F3_B:    return {4{rs2[7:0]}};
      F3_H:    return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Extracts the addressed byte/half from a read word and sign- or zero-extends
// it according to funct3.
module load_formatter
  import rv_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_offset)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_funct3)
      F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_result = {{16{w_half[15]}}, w_half};
      F3_BU:   o_result = {24'h0, w_byte};
      F3_HU:   o_result = {16'h0, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: runs one req/gnt/rvalid data-memory access
// per load/store, stalling upstream stages until the response arrives.
module mem_access_stage
  import rv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       alu_out_i,
  input  logic [DATA_W-1:0] rdata2_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic              flush_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              stall_o,
  output logic              fault_o,
  output logic [31:0]       result_o
);

  mem_state_t        r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [31:0]       r_load_q;

  logic              w_op;
  logic              w_mis;
  logic              w_start;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [31:0]       w_fmt;

  // rst_n gates the request path so every output holds its reset value while reset is asserted.
  assign w_op    = (mem_read_i | mem_write_i) & ~flush_i & rst_n;
  assign w_mis   = is_misaligned(funct3_i, alu_out_i[1:0]);
  assign w_start = (r_state == IDLE) & w_op & ~w_mis;
  assign w_addr  = {alu_out_i[ADDR_W-1:2], 2'b00};
  assign w_be    = lane_be(funct3_i, alu_out_i[1:0]);
  assign w_wdata = mem_write_i ? store_wdata(funct3_i, rdata2_i) : '0;

  load_formatter u_fmt (
    .i_rdata  (dmem_rdata_i),
    .i_offset (r_off),
    .i_funct3 (r_funct3),
    .o_result (w_fmt)
  );

  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = BE_NONE;
    dmem_wdata_o = '0;
    stall_o      = 1'b0;
    fault_o      = 1'b0;
    result_o     = alu_out_i;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          dmem_req_o   = 1'b1;
          dmem_we_o    = mem_write_i;
          dmem_addr_o  = w_addr;
          dmem_be_o    = w_be;
          dmem_wdata_o = w_wdata;
          stall_o      = 1'b1;
        end else if (w_op) begin
          fault_o  = 1'b1;
          result_o = '0;
        end
      end
      REQ: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = r_we;
        dmem_addr_o  = r_addr;
        dmem_be_o    = r_be;
        dmem_wdata_o = r_wdata;
        stall_o      = 1'b1;
      end
      WAIT: stall_o = 1'b1;
      DONE: if (!r_we) result_o = r_load_q;
      default: ;
    endcase
  end

  // gnt takes priority over a same-cycle rvalid in REQ; the bus never sends both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_be     <= BE_NONE;
      r_wdata  <= '0;
      r_funct3 <= F3_B;
      r_off    <= 2'b00;
      r_load_q <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_we     <= mem_write_i;
            r_addr   <= w_addr;
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_funct3 <= funct3_i;
            r_off    <= alu_out_i[1:0];
            r_state  <= dmem_gnt_i ? WAIT : REQ;
          end
        end
        REQ: if (dmem_gnt_i) r_state <= WAIT;
        WAIT: begin
          if (dmem_rvalid_i) begin
            if (!r_we) r_load_q <= w_fmt;
            r_state <= DONE;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: loads, stores, bus
// backpressure, faults, flush and asynchronous reset mid-transaction.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] aluOut;
  logic [31:0] rs2;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic        flush;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_out_i     (aluOut),
    .rdata2_i      (rs2),
    .mem_read_i    (memRead),
    .mem_write_i   (memWrite),
    .funct3_i      (funct3),
    .flush_i       (flush),
    .dmem_req_o    (req),
    .dmem_we_o     (we),
    .dmem_addr_o   (addr),
    .dmem_be_o     (be),
    .dmem_wdata_o  (wdata),
    .dmem_gnt_i    (gnt),
    .dmem_rvalid_i (rvalid),
    .dmem_rdata_i  (rdata),
    .stall_o       (stall),
    .fault_o       (fault),
    .result_o      (result)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic rd,
                               input logic wr, input logic [2:0] f3, input logic fl);
    aluOut   = a;
    rs2      = d;
    memRead  = rd;
    memWrite = wr;
    funct3   = f3;
    flush    = fl;
  endtask

  task automatic busInputs(input logic g, input logic v, input logic [31:0] d);
    gnt    = g;
    rvalid = v;
    rdata  = d;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBus(input string tag, input logic eReq, input logic eWe, input logic [31:0] eAddr,
                          input logic [3:0] eBe, input logic [31:0] eWdata, input logic eStall);
    checkOutput({tag, " req"}, req, eReq);
    checkOutput({tag, " we"}, we, eWe);
    checkOutput({tag, " addr"}, addr, eAddr);
    checkOutput({tag, " be"}, be, eBe);
    checkOutput({tag, " wdata"}, wdata, eWdata);
    checkOutput({tag, " stall"}, stall, eStall);
  endtask

  // Load with immediate gnt and rvalid one cycle later; ends in IDLE with a NOP presented.
  task automatic doLoad(input string tag, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] d, input logic [3:0] eBe, input logic [31:0] eRes);
    applyStimulus(a, 32'h0, 1'b1, 1'b0, f3, 1'b0);
    busInputs(1'b1, 1'b0, 32'h0);
    #2;
    checkBus({tag, " c1"}, 1'b1, 1'b0, {a[31:2], 2'b00}, eBe, 32'h0, 1'b1);
    nextCycle();
    busInputs(1'b0, 1'b1, d);
    #2;
    checkOutput({tag, " c2 stall"}, stall, 1'b1);
    checkOutput({tag, " c2 req"}, req, 1'b0);
    nextCycle();
    busInputs(1'b0, 1'b0, 32'h0);
    #2;
    checkOutput({tag, " c3 stall"}, stall, 1'b0);
    checkOutput({tag, " c3 result"}, result, eRes);
    nextCycle();
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic doStore(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] d, input logic [3:0] eBe, input logic [31:0] eWdata);
    applyStimulus(a, d, 1'b0, 1'b1, f3, 1'b0);
    busInputs(1'b1, 1'b0, 32'h0);
    #2;
    checkBus({tag, " c1"}, 1'b1, 1'b1, {a[31:2], 2'b00}, eBe, eWdata, 1'b1);
    nextCycle();
    busInputs(1'b0, 1'b1, 32'h0);
    #2;
    checkOutput({tag, " c2 stall"}, stall, 1'b1);
    nextCycle();
    busInputs(1'b0, 1'b0, 32'h0);
    #2;
    checkOutput({tag, " c3 stall"}, stall, 1'b0);
    checkOutput({tag, " c3 result"}, result, a);
    nextCycle();
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  initial begin
    // Reset with an aligned load presented: every output must still read its reset value.
    rst_n = 1'b0;
    applyStimulus(32'h74, 32'h0, 1'b1, 1'b0, 3'b010, 1'b0);
    busInputs(1'b0, 1'b0, 32'h0);
    #3;
    checkBus("reset", 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    checkOutput("reset fault", fault, 1'b0);
    checkOutput("reset result", result, 32'h74);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0);
    nextCycle();

    doLoad("lw 0x100", 32'h100, 3'b010, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    doLoad("lb 0x103", 32'h103, 3'b000, 32'h80FFFFFF, 4'b1000, 32'hFFFFFF80);
    doLoad("lbu 0x103", 32'h103, 3'b100, 32'h80FFFFFF, 4'b1000, 32'h00000080);
    doLoad("lh 0x102", 32'h102, 3'b001, 32'h80FFFFFF, 4'b1100, 32'hFFFF80FF);
    doLoad("lhu 0x102", 32'h102, 3'b101, 32'h80FFFFFF, 4'b1100, 32'h000080FF);
    doLoad("lb 0x100", 32'h100, 3'b000, 32'h80FFFF7F, 4'b0001, 32'h0000007F);
    doStore("sb 0x201", 32'h201, 3'b000, 32'h000000A5, 4'b0010, 32'hA5A5A5A5);
    doStore("sw 0x204", 32'h204, 3'b010, 32'h89ABCDEF, 4'b1111, 32'h89ABCDEF);

    // SH with gnt withheld: bus held from latched values even when rs2 changes.
    applyStimulus(32'h202, 32'h1234ABCD, 1'b0, 1'b1, 3'b001, 1'b0);
    busInputs(1'b0, 1'b0, 32'h0);
    #2;
    checkBus("sh c1", 1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCDABCD, 1'b1);
    nextCycle();
    rs2 = 32'h0;
    #2;
    checkBus("sh c2", 1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCDABCD, 1'b1);
    nextCycle();
    busInputs(1'b0, 1'b1, 32'h0);
    #2;
    checkBus("sh c3", 1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCDABCD, 1'b1);
    nextCycle();
    busInputs(1'b1, 1'b1, 32'h0);
    #2;
    checkBus("sh c4", 1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCDABCD, 1'b1);
    nextCycle();
    busInputs(1'b0, 1'b0, 32'h0);
    #2;
    checkOutput("sh wait1 req", req, 1'b0);
    checkOutput("sh wait1 stall", stall, 1'b1);
    nextCycle();
    busInputs(1'b0, 1'b1, 32'h0);
    #2;
    checkOutput("sh wait2 stall", stall, 1'b1);
    nextCycle();
    busInputs(1'b0, 1'b0, 32'h0);
    #2;
    checkOutput("sh done stall", stall, 1'b0);
    checkOutput("sh done result", result, 32'h202);
    nextCycle();

    // Misaligned and illegal accesses fault for one cycle with no request.
    applyStimulus(32'h101, 32'h0, 1'b1, 1'b0, 3'b010, 1'b0);
    #2;
    checkOutput("lw 0x101 fault", fault, 1'b1);
    checkOutput("lw 0x101 req", req, 1'b0);
    checkOutput("lw 0x101 stall", stall, 1'b0);
    checkOutput("lw 0x101 result", result, 32'h0);
    nextCycle();
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0);
    #2;
    checkOutput("after fault fault", fault, 1'b0);
    checkOutput("after fault stall", stall, 1'b0);
    nextCycle();
    applyStimulus(32'h203, 32'h0, 1'b0, 1'b1, 3'b001, 1'b0);
    #2;
    checkOutput("sh 0x203 fault", fault, 1'b1);
    checkOutput("sh 0x203 req", req, 1'b0);
    nextCycle();
    applyStimulus(32'h100, 32'h0, 1'b1, 1'b0, 3'b011, 1'b0);
    #2;
    checkOutput("f3 011 fault", fault, 1'b1);
    checkOutput("f3 011 req", req, 1'b0);
    nextCycle();

    // Non-memory op passes through; stray gnt while idle is ignored.
    applyStimulus(32'h55, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0);
    busInputs(1'b1, 1'b0, 32'h0);
    #2;
    checkOutput("add result", result, 32'h55);
    checkOutput("add req", req, 1'b0);
    checkOutput("add stall", stall, 1'b0);
    nextCycle();
    busInputs(1'b0, 1'b0, 32'h0);
    #2;
    checkOutput("stray gnt stall", stall, 1'b0);
    checkOutput("stray gnt req", req, 1'b0);
    nextCycle();
    applyStimulus(32'h100, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1);
    #2;
    checkOutput("flush req", req, 1'b0);
    checkOutput("flush stall", stall, 1'b0);
    checkOutput("flush fault", fault, 1'b0);
    checkOutput("flush result", result, 32'h100);
    nextCycle();

    // Asynchronous reset while waiting for rvalid; the late rvalid must be ignored.
    applyStimulus(32'h300, 32'h0, 1'b1, 1'b0, 3'b010, 1'b0);
    busInputs(1'b1, 1'b0, 32'h0);
    #2;
    checkOutput("rst lw req", req, 1'b1);
    nextCycle();
    busInputs(1'b0, 1'b0, 32'h0);
    #2;
    checkOutput("rst wait stall", stall, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst mid stall", stall, 1'b0);
    checkOutput("rst mid req", req, 1'b0);
    checkOutput("rst mid load_q", dut.r_load_q, 32'h0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(32'h99, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0);
    busInputs(1'b0, 1'b1, 32'h12345678);
    #2;
    checkOutput("late rvalid stall", stall, 1'b0);
    checkOutput("late rvalid req", req, 1'b0);
    checkOutput("late rvalid result", result, 32'h99);
    nextCycle();
    busInputs(1'b0, 1'b0, 32'h0);
    #2;
    checkOutput("post rvalid stall", stall, 1'b0);
    checkOutput("post rvalid result", result, 32'h99);
    checkOutput("post rvalid load_q", dut.r_load_q, 32'h0);
    nextCycle();
    doLoad("lw 0x400", 32'h400, 3'b010, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
